// File: rtl/pipeline_arbiter_round_robin_pkg.sv
// rtl/pipeline_arbiter_round_robin_pkg.sv - shared defaults and index helper for the round-robin pipeline arbiter
package pipeline_arbiter_round_robin_pkg;

   localparam int DEFAULT_WORD_WIDTH  = 8;
   localparam int DEFAULT_INPUT_COUNT = 4;
   localparam int DEFAULT_ADDR_WIDTH  = 2;

   // Single-step wrap; callers never pass a value at or beyond twice the count.
   function automatic int wrap_index(input int value, input int count);
      return (value >= count) ? value - count : value;
   endfunction

endpackage

// File: rtl/pipeline_arbiter_round_robin_arbiter.sv
// rtl/pipeline_arbiter_round_robin_arbiter.sv - combinational round-robin grant search starting at a pointer
module arbiter_round_robin
   import pipeline_arbiter_round_robin_pkg::*;
#(
   parameter int REQUEST_COUNT = DEFAULT_INPUT_COUNT,
   parameter int INDEX_WIDTH   = DEFAULT_ADDR_WIDTH
) (
   input  logic [REQUEST_COUNT-1:0] requests,
   input  logic [INDEX_WIDTH-1:0]   pointer,
   output logic [INDEX_WIDTH-1:0]   grant,
   output logic                     grant_valid
);

   int idx;

   // Scan farthest-first so the requester nearest the pointer is the last writer.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = REQUEST_COUNT - 1; k >= 0; k--) begin
         idx = wrap_index(int'(pointer) + k, REQUEST_COUNT);
         if (requests[idx]) begin
            grant       = idx[INDEX_WIDTH-1:0];
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipeline_arbiter_round_robin.sv
// rtl/pipeline_arbiter_round_robin.sv - round-robin merge of valid/ready requesters into one registered output stage
module pipeline_arbiter_round_robin
   import pipeline_arbiter_round_robin_pkg::*;
#(
   parameter int  WORD_WIDTH  = DEFAULT_WORD_WIDTH,
   parameter int  INPUT_COUNT = DEFAULT_INPUT_COUNT,
   parameter int  ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic [INPUT_COUNT-1:0] input_valid,
   output logic [INPUT_COUNT-1:0] input_ready,
   input  logic [TOTAL_WIDTH-1:0] input_data,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [WORD_WIDTH-1:0]  output_data,
   output logic [ADDR_WIDTH-1:0]  output_source
);

   logic [ADDR_WIDTH-1:0] pointer_q, pointer_d;
   logic [ADDR_WIDTH-1:0] grant;
   logic                  grant_valid;
   logic                  can_load;
   logic                  load;
   logic                  output_valid_q, output_valid_d;
   logic [WORD_WIDTH-1:0] output_data_q, output_data_d;
   logic [ADDR_WIDTH-1:0] output_source_q, output_source_d;

   arbiter_round_robin #(
      .REQUEST_COUNT (INPUT_COUNT),
      .INDEX_WIDTH   (ADDR_WIDTH)
   ) u_arbiter (
      .requests    (input_valid),
      .pointer     (pointer_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // output_ready feeds input_ready combinationally so a draining stage can refill in the same cycle.
   assign can_load = ~output_valid_q | output_ready;

   always_comb begin
      input_ready     = '0;
      load            = 1'b0;
      pointer_d       = pointer_q;
      output_valid_d  = output_valid_q;
      output_data_d   = output_data_q;
      output_source_d = output_source_q;
      if (!clear && can_load && grant_valid) begin
         input_ready[grant] = 1'b1;
         load               = input_valid[grant];
      end
      if (load) begin
         output_data_d   = input_data[grant*WORD_WIDTH +: WORD_WIDTH];
         output_source_d = grant;
         output_valid_d  = 1'b1;
         pointer_d       = (grant == ADDR_WIDTH'(INPUT_COUNT - 1)) ? '0 : grant + ADDR_WIDTH'(1);
      end else if (output_ready) begin
         output_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         pointer_q       <= '0;
         output_valid_q  <= 1'b0;
         output_data_q   <= '0;
         output_source_q <= '0;
      end else begin
         pointer_q       <= pointer_d;
         output_valid_q  <= output_valid_d;
         output_data_q   <= output_data_d;
         output_source_q <= output_source_d;
      end
   end

   assign output_valid  = output_valid_q;
   assign output_data   = output_data_q;
   assign output_source = output_source_q;

endmodule
